// File: rtl/mc_data_sync.sv
// -----------------------------------------------------------------------------
// mc_data_sync
//
// Multi-channel data synchroniser. Each channel carries an asynchronous enable
// through a NUM_STAGES flop chain. An event on the synchronised enable
// captures the channel's source word into a holding register:
//   - level mode (TOGGLE_MODE=0): the event is a rising edge of the enable.
//   - toggle mode (TOGGLE_MODE=1): the event is either edge of the enable.
// The held word is offered to a consumer with a valid/ready pair.
// Channels are fully independent; each one is a separate generate instance.
//
// Ports
//   clk          in   destination clock
//   rst          in   synchronous active-high reset
//   unsync_bus   in   [NUM_CH*BUS_WIDTH] source data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable   in   [NUM_CH] asynchronous per-channel enable
//   sync_ready   in   [NUM_CH] consumer accepts the held word
//   overrun_clr  in   clears every overrun flag
//   sync_bus     out  [NUM_CH*BUS_WIDTH] captured data, same packing as unsync_bus
//   enable_pulse out  [NUM_CH] one-cycle strobe in the cycle after a capture
//   sync_valid   out  [NUM_CH] held word not yet accepted
//   ack          out  [NUM_CH] synchronised enable level returned to the source
//   overrun      out  [NUM_CH] sticky: a capture replaced an unaccepted word
//
// Handshake: a word is transferred on a clock edge where sync_valid=1 and
// sync_ready=1. sync_valid rises on the capturing edge and falls on a
// transfer edge that has no new capture. A capture on a transfer edge
// replaces the accepted word, so sync_valid stays high and no overrun is
// flagged. A capture while sync_valid=1 and sync_ready=0 replaces a word the
// consumer never saw and sets overrun. sync_ready while sync_valid=0 is ignored.
// -----------------------------------------------------------------------------
module mc_data_sync #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic                        overrun_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           ack,
  output logic [NUM_CH-1:0]           overrun
);

  for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
    logic [NUM_STAGES-1:0] r_sync;
    logic                  r_sen_d;
    logic [BUS_WIDTH-1:0]  r_data;
    logic                  r_pulse;
    logic                  r_valid;
    logic                  r_ovr;

    logic                  w_sen;
    logic                  w_event;
    logic                  w_ovr_set;
    logic                  w_accept;

    // Last chain stage is the synchronised enable.
    assign w_sen = r_sync[NUM_STAGES-1];

    if (TOGGLE_MODE != 0) begin : g_toggle
      assign w_event = w_sen ^ r_sen_d;
    end else begin : g_level
      assign w_event = w_sen & ~r_sen_d;
    end

    // Only a capture onto an unaccepted word is an overrun.
    assign w_ovr_set = w_event & r_valid & ~sync_ready[gc];
    assign w_accept  = r_valid & sync_ready[gc];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync  <= '0;
        r_sen_d <= 1'b0;
        r_data  <= '0;
        r_pulse <= 1'b0;
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        r_sync  <= {r_sync[NUM_STAGES-2:0], bus_enable[gc]};
        r_sen_d <= w_sen;
        r_pulse <= w_event;

        if (w_event) begin
          r_data  <= unsync_bus[gc*BUS_WIDTH +: BUS_WIDTH];
          r_valid <= 1'b1;
        end else if (w_accept) begin
          r_valid <= 1'b0;
        end

        // A set on the same edge as a clear wins.
        if (w_ovr_set) begin
          r_ovr <= 1'b1;
        end else if (overrun_clr) begin
          r_ovr <= 1'b0;
        end
      end
    end

    assign sync_bus[gc*BUS_WIDTH +: BUS_WIDTH] = r_data;
    assign enable_pulse[gc]                    = r_pulse;
    assign sync_valid[gc]                      = r_valid;
    assign ack[gc]                             = r_sen_d;
    assign overrun[gc]                         = r_ovr;
  end

endmodule

// File: tb/tb_mc_data_sync.sv
// -----------------------------------------------------------------------------
// tb_mc_data_sync
//
// Bench for mc_data_sync with NUM_STAGES=2, BUS_WIDTH=8, NUM_CH=2. One level
// mode and one toggle mode instance share the same stimulus. A delay-line
// reference model follows both instances every cycle; a directed vector
// table and hand-written sequences cover latency, overrun, same-edge accept,
// toggle events and a mid-operation reset.
// -----------------------------------------------------------------------------
module tb_mc_data_sync;
  localparam int NS = 2;
  localparam int BW = 8;
  localparam int NC = 2;

  // ---------------- clock / reset / stimulus signals ----------------
  logic              clk;
  logic              rst;
  logic [NC*BW-1:0]  unsync_bus;
  logic [NC-1:0]     bus_enable;
  logic [NC-1:0]     sync_ready;
  logic              overrun_clr;

  logic [NC*BW-1:0]  l_bus,   t_bus;
  logic [NC-1:0]     l_pulse, t_pulse;
  logic [NC-1:0]     l_valid, t_valid;
  logic [NC-1:0]     l_ack,   t_ack;
  logic [NC-1:0]     l_ovr,   t_ovr;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NC), .TOGGLE_MODE(0)) u_lvl (
    .clk(clk), .rst(rst), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_ready(sync_ready), .overrun_clr(overrun_clr), .sync_bus(l_bus),
    .enable_pulse(l_pulse), .sync_valid(l_valid), .ack(l_ack), .overrun(l_ovr));

  mc_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NC), .TOGGLE_MODE(1)) u_tog (
    .clk(clk), .rst(rst), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_ready(sync_ready), .overrun_clr(overrun_clr), .sync_bus(t_bus),
    .enable_pulse(t_pulse), .sync_valid(t_valid), .ack(t_ack), .overrun(t_ovr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[c][j] is the enable sampled j+1 edges ago. The synchroniser output
  // seen at an edge is the enable from NS edges before it; the previous
  // synchronised value is one sample older still.
  logic       hist    [NC][NS+1];
  logic [7:0] m_bus   [2][NC];
  logic       m_pulse [2][NC];
  logic       m_valid [2][NC];
  logic       m_ovr   [2][NC];
  logic       m_ack   [NC];
  logic       seen_rst = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      seen_rst = 1'b1;
      for (int c = 0; c < NC; c++) begin
        for (int j = 0; j <= NS; j++) hist[c][j] = 1'b0;
        m_ack[c] = 1'b0;
        for (int m = 0; m < 2; m++) begin
          m_bus[m][c] = 8'h00; m_pulse[m][c] = 1'b0;
          m_valid[m][c] = 1'b0; m_ovr[m][c] = 1'b0;
        end
      end
    end else if (seen_rst) begin
      for (int c = 0; c < NC; c++) begin
        logic s_new, s_old, ev, v, r;
        s_new = hist[c][NS-1];
        s_old = hist[c][NS];
        r     = sync_ready[c];
        for (int m = 0; m < 2; m++) begin
          ev = (m == 1) ? (s_new ^ s_old) : (s_new & ~s_old);
          v  = m_valid[m][c];
          m_pulse[m][c] = ev;
          if (ev) begin
            m_bus[m][c]   = unsync_bus[c*BW +: BW];
            m_valid[m][c] = 1'b1;
            if (v && !r) m_ovr[m][c] = 1'b1;
            else if (overrun_clr) m_ovr[m][c] = 1'b0;
          end else begin
            if (v && r) m_valid[m][c] = 1'b0;
            if (overrun_clr) m_ovr[m][c] = 1'b0;
          end
        end
        for (int j = NS; j >= 1; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = bus_enable[c];
        m_ack[c]   = hist[c][NS];
      end
    end
  end

  // ---------------- scoreboard: model vs both instances ----------------
  always @(negedge clk) begin
    if (seen_rst) begin
      for (int m = 0; m < 2; m++) begin
        logic [NC*BW-1:0] e_bus;
        logic [NC-1:0]    e_pulse, e_valid, e_ack, e_ovr;
        for (int c = 0; c < NC; c++) begin
          e_bus[c*BW +: BW] = m_bus[m][c];
          e_pulse[c] = m_pulse[m][c];
          e_valid[c] = m_valid[m][c];
          e_ack[c]   = m_ack[c];
          e_ovr[c]   = m_ovr[m][c];
        end
        if (m == 0) begin
          chk("model_lvl_bus",   32'(l_bus),   32'(e_bus));
          chk("model_lvl_pulse", 32'(l_pulse), 32'(e_pulse));
          chk("model_lvl_valid", 32'(l_valid), 32'(e_valid));
          chk("model_lvl_ack",   32'(l_ack),   32'(e_ack));
          chk("model_lvl_ovr",   32'(l_ovr),   32'(e_ovr));
        end else begin
          chk("model_tog_bus",   32'(t_bus),   32'(e_bus));
          chk("model_tog_pulse", 32'(t_pulse), 32'(e_pulse));
          chk("model_tog_valid", 32'(t_valid), 32'(e_valid));
          chk("model_tog_ack",   32'(t_ack),   32'(e_ack));
          chk("model_tog_ovr",   32'(t_ovr),   32'(e_ovr));
        end
      end
    end
  end

  // ---------------- directed vector table (level instance, channel 0) ----------------
  typedef struct {
    logic       rst;
    logic       en0;
    logic [7:0] d0;
    logic       rdy0;
    logic       clr;
    logic       e_pulse;
    logic       e_valid;
    logic       e_ack;
    logic       e_ovr;
    logic [7:0] e_bus;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic r, input logic en, input logic [7:0] d, input logic rdy,
                         input logic clr, input logic p, input logic v, input logic a,
                         input logic o, input logic [7:0] b);
    vec_t t;
    t.rst = r; t.en0 = en; t.d0 = d; t.rdy0 = rdy; t.clr = clr;
    t.e_pulse = p; t.e_valid = v; t.e_ack = a; t.e_ovr = o; t.e_bus = b;
    vq.push_back(t);
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         cnt_l0, cnt_l1, cnt_t0, cnt_t1;
  logic [7:0] cap;

  initial begin
    rst = 1'b1; unsync_bus = '0; bus_enable = '0; sync_ready = '0; overrun_clr = 1'b0;

    //       rst en  data   rdy clr  pulse valid ack ovr bus
    add_vec(1, 0, 8'h00, 0, 0,   0, 0, 0, 0, 8'h00); // reset
    add_vec(0, 1, 8'hA5, 0, 0,   0, 0, 0, 0, 8'h00); // enable rises before edge 1
    add_vec(0, 1, 8'hA5, 0, 0,   0, 0, 0, 0, 8'h00);
    add_vec(0, 1, 8'hA5, 0, 0,   1, 1, 1, 0, 8'hA5); // capture after edge 3
    add_vec(0, 1, 8'hA5, 0, 0,   0, 1, 1, 0, 8'hA5); // held high: single pulse
    add_vec(0, 0, 8'h3C, 0, 0,   0, 1, 1, 0, 8'hA5);
    add_vec(0, 0, 8'h3C, 0, 0,   0, 1, 1, 0, 8'hA5);
    add_vec(0, 1, 8'h3C, 0, 0,   0, 1, 0, 0, 8'hA5);
    add_vec(0, 1, 8'h3C, 0, 0,   0, 1, 0, 0, 8'hA5);
    add_vec(0, 1, 8'h3C, 0, 1,   1, 1, 1, 1, 8'h3C); // overrun set beats clear
    add_vec(0, 1, 8'h3C, 0, 1,   0, 1, 1, 0, 8'h3C); // clear
    add_vec(0, 0, 8'h5A, 0, 0,   0, 1, 1, 0, 8'h3C);
    add_vec(0, 0, 8'h5A, 0, 0,   0, 1, 1, 0, 8'h3C);
    add_vec(0, 1, 8'h5A, 0, 0,   0, 1, 0, 0, 8'h3C);
    add_vec(0, 1, 8'h5A, 0, 0,   0, 1, 0, 0, 8'h3C);
    add_vec(0, 1, 8'h5A, 1, 0,   1, 1, 1, 0, 8'h5A); // capture with ready: no overrun
    add_vec(0, 1, 8'h5A, 1, 0,   0, 0, 1, 0, 8'h5A); // accepted
    add_vec(0, 1, 8'h5A, 1, 0,   0, 0, 1, 0, 8'h5A); // ready while empty: no effect
    add_vec(0, 1, 8'h5A, 0, 0,   0, 0, 1, 0, 8'h5A);

    for (int i = 0; i < vq.size(); i++) begin
      rst           = vq[i].rst;
      bus_enable[0] = vq[i].en0;
      unsync_bus[7:0] = vq[i].d0;
      sync_ready[0] = vq[i].rdy0;
      overrun_clr   = vq[i].clr;
      step();
      chk($sformatf("vec%0d_pulse", i), 32'(l_pulse[0]), 32'(vq[i].e_pulse));
      chk($sformatf("vec%0d_valid", i), 32'(l_valid[0]), 32'(vq[i].e_valid));
      chk($sformatf("vec%0d_ack", i),   32'(l_ack[0]),   32'(vq[i].e_ack));
      chk($sformatf("vec%0d_ovr", i),   32'(l_ovr[0]),   32'(vq[i].e_ovr));
      chk($sformatf("vec%0d_bus", i),   32'(l_bus[7:0]), 32'(vq[i].e_bus));
    end
    sync_ready = '0; overrun_clr = 1'b0;

    // ---- toggle mode, channel 1: rise with 0x11, fall with 0x22, 6 cycles apart ----
    cnt_t1 = 0; cnt_l1 = 0; cap = 8'h00;
    bus_enable[1] = 1'b1; unsync_bus[15:8] = 8'h11;
    for (int i = 0; i < 6; i++) begin
      step();
      if (t_pulse[1]) begin cnt_t1++; cap = t_bus[15:8]; end
      cnt_l1 += int'(l_pulse[1]);
    end
    chk("tog_rise_pulses", 32'(cnt_t1), 32'd1);
    chk("tog_rise_data",   32'(cap), 32'h11);
    chk("tog_rise_ack",    32'(t_ack[1]), 32'd1);
    cnt_t1 = 0;
    bus_enable[1] = 1'b0; unsync_bus[15:8] = 8'h22;
    for (int i = 0; i < 6; i++) begin
      step();
      if (t_pulse[1]) begin cnt_t1++; cap = t_bus[15:8]; end
      cnt_l1 += int'(l_pulse[1]);
    end
    chk("tog_fall_pulses", 32'(cnt_t1), 32'd1);
    chk("tog_fall_data",   32'(cap), 32'h22);
    chk("tog_fall_ack",    32'(t_ack[1]), 32'd0);
    chk("lvl_ch1_pulses",  32'(cnt_l1), 32'd1);

    // ---- mid-operation reset: ch0 transition flushed, ch1 held high ----
    bus_enable = 2'b10; unsync_bus = 16'h77_00;
    repeat (4) step();
    bus_enable[0] = 1'b1;
    step();
    rst = 1'b1; bus_enable[0] = 1'b0;
    step();
    chk("rst_lvl_outs", {l_bus, l_pulse, l_valid, l_ack, l_ovr}, 32'd0);
    chk("rst_tog_outs", {t_bus, t_pulse, t_valid, t_ack, t_ovr}, 32'd0);
    rst = 1'b0; unsync_bus = 16'h99_00;
    cnt_l0 = 0; cnt_l1 = 0; cnt_t0 = 0; cnt_t1 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt_l0 += int'(l_pulse[0]); cnt_l1 += int'(l_pulse[1]);
      cnt_t0 += int'(t_pulse[0]); cnt_t1 += int'(t_pulse[1]);
    end
    chk("flush_lvl_ch0", 32'(cnt_l0), 32'd0);
    chk("flush_tog_ch0", 32'(cnt_t0), 32'd0);
    chk("exit_lvl_ch1",  32'(cnt_l1), 32'd1);
    chk("exit_tog_ch1",  32'(cnt_t1), 32'd1);
    chk("exit_lvl_data", 32'(l_bus[15:8]), 32'h99);

    // ---- randomized traffic, checked by the model every cycle ----
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 149) == 0);
      overrun_clr = ($urandom_range(0, 7) == 0);
      unsync_bus  = 16'($urandom);
      sync_ready  = 2'($urandom_range(0, 3));
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 3) == 0) bus_enable[c] = ~bus_enable[c];
      step();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_data_sync.md
MC_DATA_SYNC -- requirements
Module: mc_data_sync

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, synchroniser depth for each enable; legal values >= 2.
REQ-002 SHALL have parameter BUS_WIDTH, default 8, data width per channel.
REQ-003 SHALL have parameter NUM_CH, default 2, number of independent channels; legal values >= 1.
REQ-004 SHALL have parameter TOGGLE_MODE, default 0; 0 = level enable (rising edge is the event), 1 = toggle enable (either edge is the event).
REQ-005 SHALL have port clk  input  1  destination clock; the single clock of the block.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port unsync_bus  input  NUM_CH*BUS_WIDTH  source data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
REQ-008 SHALL have port bus_enable  input  NUM_CH  asynchronous per-channel enable, one bit per channel.
REQ-009 SHALL have port sync_ready  input  NUM_CH  consumer accepts the held word of channel c.
REQ-010 SHALL have port overrun_clr  input  1  clears all overrun flags.
REQ-011 SHALL have port sync_bus  output  NUM_CH*BUS_WIDTH  captured data, same packing as unsync_bus.
REQ-012 SHALL have port enable_pulse  output  NUM_CH  one-cycle capture strobe per channel.
REQ-013 SHALL have port sync_valid  output  NUM_CH  held word not yet accepted.
REQ-014 SHALL have port ack  output  NUM_CH  synchronised enable level returned to the source for handshake closure.
REQ-015 SHALL have port overrun  output  NUM_CH  sticky flag: a capture overwrote an unaccepted word.

Function
REQ-016 Each channel SHALL be fully independent; no channel's state SHALL affect another's.
REQ-017 Each bus_enable bit SHALL pass through a NUM_STAGES flop shift chain; the last stage is the synchronised enable (sen).
REQ-018 A registered copy of sen (sen_d) SHALL exist per channel; ack SHALL equal sen_d.
REQ-019 Event definition: TOGGLE_MODE=0 -> event = sen & ~sen_d; TOGGLE_MODE=1 -> event = sen ^ sen_d.
REQ-020 On a clock edge where event=1: sync_bus channel SHALL load unsync_bus channel, and enable_pulse SHALL be 1 for exactly the following cycle.
REQ-021 Otherwise sync_bus SHALL hold its value and enable_pulse SHALL be 0.
REQ-022 Latency: an enable transition set up before edge 1 SHALL give enable_pulse/sync_bus update after edge NUM_STAGES+1 and ack change after edge NUM_STAGES+1.
REQ-023 sync_valid SHALL set on the capturing edge and clear on an edge where sync_valid=1, sync_ready=1 and no capture occurs.
REQ-024 Capture and sync_ready=1 on the same edge: new word SHALL load, sync_valid SHALL stay 1, overrun SHALL NOT set.
REQ-025 Capture while sync_valid=1 and sync_ready=0: new word SHALL overwrite, sync_valid SHALL stay 1, overrun SHALL set.
REQ-026 overrun SHALL hold until an edge with overrun_clr=1; a set condition on the same edge SHALL win over the clear.
REQ-027 sync_ready while sync_valid=0 SHALL have no effect.
REQ-028 In level mode a held-high bus_enable SHALL produce exactly one capture; the next capture requires a low phase of at least NUM_STAGES cycles.

Reset
REQ-029 On an edge with rst=1: all synchroniser stages, sen_d, sync_bus, enable_pulse, sync_valid, ack and overrun SHALL be 0.
REQ-030 Reset SHALL override all other inputs, including a capture or overrun set on the same edge.
REQ-031 After rst deasserts with bus_enable already 1, level mode SHALL generate one capture; toggle mode SHALL also generate one capture, since sen changes from its reset value 0.

Verification
REQ-032 NUM_STAGES=2, level, ch0: unsync_bus=0xA5, bus_enable 0->1 before edge 1 -> enable_pulse[0]=1 only in the cycle after edge 3, sync_bus[7:0]=0xA5, sync_valid[0]=1, ack[0]=1 after edge 3.
REQ-033 Toggle mode: bus_enable[1] 0->1 with data 0x11, then 1->0 with data 0x22, 6 cycles apart -> two pulses, sync_bus ch1 = 0x11 then 0x22, ack[1] follows 1 then 0.
REQ-034 Overrun: two captures on ch0 with sync_ready=0 -> second word held, overrun[0]=1; overrun_clr pulse -> overrun[0]=0; sync_ready=1 one cycle -> sync_valid[0]=0.
REQ-035 Same-edge accept: sync_ready[0]=1 on the capturing edge of a second word -> sync_valid stays 1, overrun[0]=0.
REQ-036 Mid-operation reset: rst=1 one cycle while ch0 enable is in the synchroniser chain -> all outputs 0, no pulse from the flushed transition; channel 1 concurrently active -> unaffected after reset exit except per REQ-031.
